// File: rtl/tl_tag_pkg.sv
// Shared types and defaults for the transaction-layer tag allocation arbiter.
package tl_tag_pkg;

    localparam int TAG_W_DEF     = 8;
    localparam int NUM_REQ_DEF   = 2;
    localparam int STALL_THR_DEF = 64;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } arb_state_e;

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module tl_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        any     = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        sel     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sel = IDX_W'((32'(rr_ptr) + 32'(off)) % 32'(NUM_REQ));
            if (!any && req[sel]) begin
                any         = 1'b1;
                gnt_oh[sel] = 1'b1;
                gnt_idx     = sel;
            end
        end
    end

endmodule

// File: rtl/tl_tag_alloc_arb.sv
// Round-robin arbiter sharing the tag table among non-posted requesters; forwards frees.
// Optional per-requester outstanding-tag limit: define TL_TAG_ARB_OUTST_LIMIT_EN.
module tl_tag_alloc_arb
    import tl_tag_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int TAG_W     = TAG_W_DEF,
    parameter  int MAX_OUTST = 16,
    parameter  int STALL_THR = STALL_THR_DEF,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int WCNT_W    = $clog2(STALL_THR + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               tt_alloc_req_o,
    input  logic [TAG_W-1:0]   tt_alloc_tag_i,
    input  logic               tt_alloc_gnt_i,
    input  logic               cpl_free_valid_i,
    input  logic [TAG_W-1:0]   cpl_free_tag_i,
    input  logic [ID_W-1:0]    cpl_free_req_id_i,
    output logic               tt_free_valid_o,
    output logic [TAG_W-1:0]   tt_free_tag_o,
    output logic               stall_o
);

    arb_state_e         state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, winner;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [NUM_REQ-1:0] elig, pick_oh;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               alloc_done;

    assign alloc_done      = (state == WAIT) && tt_alloc_gnt_i;
    assign tt_free_valid_o = cpl_free_valid_i;
    assign tt_free_tag_o   = cpl_free_tag_i;
    assign stall_o         = (wait_cnt >= WCNT_W'(STALL_THR));

    tl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (elig),
        .rr_ptr  (rr_ptr),
        .any     (pick_any),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            winner   <= '0;
            rr_ptr   <= '0;
            tag_o    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any)
                winner <= pick_idx;
            if (alloc_done) begin
                tag_o  <= tt_alloc_tag_i;
                rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state == WAIT && !tt_alloc_gnt_i) begin
                if (wait_cnt != '1)
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        tt_alloc_req_o = 1'b0;
        req_ready_o    = '0;
        case (state)
            IDLE:  if (pick_any) state_nxt = WAIT;
            WAIT: begin
                tt_alloc_req_o = 1'b1;
                if (tt_alloc_gnt_i) state_nxt = GRANT;
            end
            GRANT: begin
                req_ready_o[winner] = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TL_TAG_ARB_OUTST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [NUM_REQ-1:0][CNT_W-1:0] outst_cnt;
    logic [NUM_REQ-1:0]            full;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_cnt
        logic inc, dec;
        assign inc     = alloc_done && (winner == ID_W'(r));
        assign dec     = cpl_free_valid_i && (cpl_free_req_id_i == ID_W'(r));
        assign full[r] = (outst_cnt[r] == CNT_W'(MAX_OUTST));

        // A simultaneous grant and free to the same requester cancel out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                outst_cnt[r] <= '0;
            else if (inc && !dec)
                outst_cnt[r] <= outst_cnt[r] + 1'b1;
            else if (dec && !inc && outst_cnt[r] != '0)
                outst_cnt[r] <= outst_cnt[r] - 1'b1;
        end

        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(dec && !inc && outst_cnt[r] == '0));
    end

    assign elig = req_valid_i & ~full;
`else
    logic unused_cfg;
    assign unused_cfg = ^{cpl_free_req_id_i, 32'(MAX_OUTST)};
    assign elig       = req_valid_i;
`endif

    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT) |-> req_valid_i[winner]);

endmodule

// File: tb/tb_tl_tag_alloc_arb.sv
// Directed self-checking bench for tl_tag_alloc_arb (NUM_REQ=2, TAG_W=8, MAX_OUTST=2).
module tb_tl_tag_alloc_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] tag;
    logic       tt_alloc_req;
    logic [7:0] tt_alloc_tag;
    logic       tt_alloc_gnt;
    logic       cpl_free_valid;
    logic [7:0] cpl_free_tag;
    logic [0:0] cpl_free_req_id;
    logic       tt_free_valid;
    logic [7:0] tt_free_tag;
    logic       stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_tag_alloc_arb #(.NUM_REQ(2), .TAG_W(8), .MAX_OUTST(2), .STALL_THR(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .tag_o             (tag),
        .tt_alloc_req_o    (tt_alloc_req),
        .tt_alloc_tag_i    (tt_alloc_tag),
        .tt_alloc_gnt_i    (tt_alloc_gnt),
        .cpl_free_valid_i  (cpl_free_valid),
        .cpl_free_tag_i    (cpl_free_tag),
        .cpl_free_req_id_i (cpl_free_req_id),
        .tt_free_valid_o   (tt_free_valid),
        .tt_free_tag_o     (tt_free_tag),
        .stall_o           (stall)
    );

    task automatic idle_inputs();
        req_valid       = 2'b00;
        tt_alloc_tag    = 8'h00;
        tt_alloc_gnt    = 1'b0;
        cpl_free_valid  = 1'b0;
        cpl_free_tag    = 8'h00;
        cpl_free_req_id = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Raise req_valid, act as a tag table granting after gnt_delay WAIT cycles,
    // and report the first ready pulse; lat = edges from valid to ready (-1 on timeout).
    task automatic run_alloc(input logic [1:0] vmask, input logic [7:0] t, input int gnt_delay,
                             output logic [1:0] rdy, output logic [7:0] tg, output int lat);
        int wcnt = 0;
        rdy = 2'b00; tg = 8'h00; lat = -1;
        req_valid = vmask;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (req_ready != 2'b00) begin
                rdy = req_ready; tg = tag; lat = c;
                tt_alloc_gnt = 1'b0;
                break;
            end
            if (tt_alloc_req) begin
                wcnt++;
                tt_alloc_tag = t;
                tt_alloc_gnt = (wcnt > gnt_delay);
            end else begin
                tt_alloc_gnt = 1'b0;
            end
        end
        tt_alloc_gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want=00", req_ready); end
        checks++; if (tag !== 8'h00) begin errors++; $display("FAIL reset_tag got=%h want=00", tag); end
        checks++; if (tt_alloc_req !== 1'b0) begin errors++; $display("FAIL reset_alloc_req got=%b want=0", tt_alloc_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [1:0] rdy; logic [7:0] tg; int lat;
        apply_reset();
        run_alloc(2'b01, 8'h05, 0, rdy, tg, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got=%0d want=2", lat); end
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL single_ready got=%b want=01", rdy); end
        checks++; if (tg !== 8'h05) begin errors++; $display("FAIL single_tag got=%h want=05", tg); end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_pulse_width got=%b want=00", req_ready); end
    endtask

    task automatic test_fairness();
        logic [1:0] rdy, exp_rdy; logic [7:0] tg; int lat;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_alloc(2'b11, 8'(i), 0, rdy, tg, lat);
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL fair_ready[%0d] got=%b want=%b", i, rdy, exp_rdy); end
            checks++; if (tg !== 8'(i)) begin errors++; $display("FAIL fair_tag[%0d] got=%h want=%h", i, tg, 8'(i)); end
            checks++; if (lat !== ((i == 0) ? 2 : 3)) begin errors++; $display("FAIL fair_latency[%0d] got=%0d want=%0d", i, lat, (i == 0) ? 2 : 3); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_exhaustion();
        logic req_held = 1'b1;
        apply_reset();
        req_valid = 2'b01;
        @(posedge clk); #1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            if (tt_alloc_req !== 1'b1) req_held = 1'b0;
            if (k == 63) begin
                checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early got=%b want=0", stall); end
            end
            if (k == 64) begin
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_rise got=%b want=1", stall); end
            end
        end
        checks++; if (req_held !== 1'b1) begin errors++; $display("FAIL stall_alloc_req_held got=%b want=1", req_held); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold got=%b want=1", stall); end
        tt_alloc_tag = 8'h2A; tt_alloc_gnt = 1'b1;
        @(posedge clk); #1;
        tt_alloc_gnt = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear got=%b want=0", stall); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_ready got=%b want=01", req_ready); end
        checks++; if (tag !== 8'h2A) begin errors++; $display("FAIL stall_tag got=%h want=2a", tag); end
        req_valid = 2'b00;
    endtask

    task automatic test_free_during_grant();
        logic [1:0] rdy; logic [7:0] tg; int lat;
        apply_reset();
        cpl_free_valid = 1'b1; cpl_free_tag = 8'h7E; #1;
        checks++; if (tt_free_tag !== 8'h7E || tt_free_valid !== 1'b1) begin errors++; $display("FAIL free_idle got=%b/%h want=1/7e", tt_free_valid, tt_free_tag); end
        cpl_free_valid = 1'b0;
        run_alloc(2'b01, 8'h10, 0, rdy, tg, lat);
        req_valid = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tt_alloc_req !== 1'b1) begin errors++; $display("FAIL free_wait got=%b want=1", tt_alloc_req); end
        tt_alloc_tag = 8'h11; tt_alloc_gnt = 1'b1;
        cpl_free_valid = 1'b1; cpl_free_tag = 8'h03; cpl_free_req_id = 1'b0;
        #1;
        checks++; if (tt_free_valid !== 1'b1) begin errors++; $display("FAIL free_valid got=%b want=1", tt_free_valid); end
        checks++; if (tt_free_tag !== 8'h03) begin errors++; $display("FAIL free_tag got=%h want=03", tt_free_tag); end
        @(posedge clk); #1;
        tt_alloc_gnt = 1'b0; cpl_free_valid = 1'b0;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL free_grant_ready got=%b want=01", req_ready); end
        checks++; if (tag !== 8'h11) begin errors++; $display("FAIL free_grant_tag got=%h want=11", tag); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] rdy; logic [7:0] tg; int lat;
        apply_reset();
        req_valid = 2'b10;
        @(posedge clk); #1;
        checks++; if (tt_alloc_req !== 1'b1) begin errors++; $display("FAIL rstwait_enter got=%b want=1", tt_alloc_req); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tt_alloc_req !== 1'b0) begin errors++; $display("FAIL rstwait_alloc_drop got=%b want=0", tt_alloc_req); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rstwait_no_ready got=%b want=00", req_ready); end
        req_valid = 2'b00;
        rst_n = 1'b1;
        run_alloc(2'b10, 8'h33, 0, rdy, tg, lat);
        checks++; if (rdy !== 2'b10 || tg !== 8'h33 || lat !== 2) begin errors++; $display("FAIL rstwait_recover got=%b/%h/%0d want=10/33/2", rdy, tg, lat); end
        req_valid = 2'b00;
    endtask

`ifdef TL_TAG_ARB_OUTST_LIMIT_EN
    task automatic test_outst_limit();
        logic [1:0] rdy; logic [7:0] tg; int lat;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            run_alloc(2'b01, 8'(8'h40 + i), 0, rdy, tg, lat);
            req_valid = 2'b00;
        end
        for (int i = 0; i < 2; i++) begin
            run_alloc(2'b11, 8'(8'h50 + i), 0, rdy, tg, lat);
            checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL limit_only_req1[%0d] got=%b want=10", i, rdy); end
        end
        req_valid = 2'b00;
        cpl_free_valid = 1'b1; cpl_free_tag = 8'h40; cpl_free_req_id = 1'b0;
        @(posedge clk); #1;
        cpl_free_valid = 1'b0;
        run_alloc(2'b11, 8'h60, 0, rdy, tg, lat);
        checks++; if (rdy !== 2'b01 || tg !== 8'h60) begin errors++; $display("FAIL limit_req0_again got=%b/%h want=01/60", rdy, tg); end
        req_valid = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_exhaustion();
        test_free_during_grant();
        test_reset_in_wait();
`ifdef TL_TAG_ARB_OUTST_LIMIT_EN
        test_outst_limit();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
